// File: rtl/word_byte_serializer_pkg.sv
// Shared constants and state encoding
// for the word-to-byte serializer.
package word_byte_serializer_pkg;

   localparam int BYTE_W = 8;
   localparam int BYTES  = 4;
   localparam int WORD_W = BYTE_W * BYTES;
   localparam int IDX_W  = $clog2(BYTES);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/word_byte_select.sv
// Combinational byte picker; index 0
// selects the most-significant byte.
module word_byte_select
   import word_byte_serializer_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [IDX_W-1:0]  idx,
   output logic [BYTE_W-1:0] sel
);

   always_comb begin
      sel = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (idx == IDX_W'(i)) begin
            sel = word[(BYTES-1-i)*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

// File: rtl/word_byte_serializer.sv
// Splits a 32-bit word into four bytes,
// MSB first, with per-byte handshakes.
module word_byte_serializer
   import word_byte_serializer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_last,
   output logic [IDX_W-1:0]  out_idx
);

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  word_q, word_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               last_idx;
   logic               in_fire;
   logic               out_fire;

   assign last_idx  = (idx_q == IDX_W'(BYTES-1));
   assign out_valid = (state_q == SEND);
   assign out_fire  = out_valid & out_ready;
   assign out_last  = out_valid & last_idx;
   assign out_idx   = idx_q;

   // Last-byte pass-through keeps words
   // back-to-back with no bubble.
   assign in_ready = ~reset &
      ((state_q == IDLE) | (out_fire & last_idx));
   assign in_fire  = in_valid & in_ready;

   word_byte_select u_sel (
      .word (word_q),
      .idx  (idx_q),
      .sel  (out_data)
   );

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (in_fire) begin
               word_d  = in_data;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (out_fire) begin
               if (!last_idx) begin
                  idx_d = idx_q + IDX_W'(1);
               end else if (in_fire) begin
                  word_d = in_data;
                  idx_d  = '0;
               end else begin
                  idx_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         word_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Scoreboard bench for the serializer:
// driver pushes bytes, monitor pops them.
module tb_word_byte_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  out_idx;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] i;
      logic       l;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   word_byte_serializer dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_idx   (out_idx)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h",
                  nm, act, req);
      end
   endtask

   task automatic push(input logic [31:0] w);
      logic [31:0] t;
      exp_t e;
      t = w;
      for (int b = 0; b < 4; b++) begin
         e.d = t[31-8*b -: 8];
         e.i = 2'(b);
         e.l = (b == 3);
         q.push_back(e);
      end
   endtask

   // Called at a falling edge; returns at the next one.
   task automatic step(input logic iv,
                       input logic [31:0] id,
                       input logic ordy,
                       output logic fired);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      fired = in_valid && in_ready;
      if (fired) push(id);
      @(negedge clk);
   endtask

   // Monitor: pop and compare on every byte handshake.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && out_valid && out_ready) begin
            a = '{d: out_data, i: out_idx, l: out_last};
            if (q.size() == 0) begin
               chk("unexpected_byte", 32'(a), 32'hFFFF_FFFF);
            end else begin
               e = q.pop_front();
               chk("byte", 32'(a), 32'(e));
            end
         end
      end
   end

   initial begin
      logic f;
      logic [1:0] pidx;
      logic [31:0] nxt;
      int words;
      int cyc;

      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      reset = 1'b0;

      // 1: single word, MSB first, one cycle latency
      step(1'b1, 32'hDEADBEEF, 1'b1, f);
      chk("t1_accept", 32'(f), 32'd1);
      chk("t1_lat_valid", 32'(out_valid), 32'd1);
      chk("t1_first", 32'(out_data), 32'hDE);
      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h0, 1'b1, f);
      chk("t1_idle", 32'(out_valid), 32'd0);
      chk("t1_drained", 32'(q.size()), 32'd0);

      // 2: back-to-back, second fire on last byte
      step(1'b1, 32'h01020304, 1'b1, f);
      chk("t2_accept0", 32'(f), 32'd1);
      for (int i = 0; i < 4; i++) begin
         pidx = out_idx;
         step(1'b1, 32'h0A0B0C0D, 1'b1, f);
         chk("t2_fire_on_last", 32'(f),
             32'(pidx == 2'd3));
         chk("t2_no_gap", 32'(out_valid), 32'd1);
      end
      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h0, 1'b1, f);
      chk("t2_idle", 32'(out_valid), 32'd0);

      // 3: stall on byte 22
      step(1'b1, 32'h11223344, 1'b1, f);
      step(1'b0, 32'h0, 1'b1, f);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'h0, 1'b0, f);
         chk("t3_hold_data", 32'(out_data), 32'h22);
         chk("t3_hold_idx", 32'(out_idx), 32'd1);
         chk("t3_in_ready", 32'(in_ready), 32'd0);
      end
      for (int i = 0; i < 3; i++)
         step(1'b0, 32'h0, 1'b1, f);
      chk("t3_idle", 32'(out_valid), 32'd0);

      // 4: reset mid-word at idx 2
      step(1'b1, 32'hCAFEF00D, 1'b1, f);
      step(1'b0, 32'h0, 1'b1, f);
      step(1'b0, 32'h0, 1'b1, f);
      chk("t4_idx2", 32'(out_idx), 32'd2);
      reset = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("t4_rst_in_ready", 32'(in_ready), 32'd0);
      q.delete();
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      chk("t4_valid_gone", 32'(out_valid), 32'd0);
      #1;
      chk("t4_in_ready_back", 32'(in_ready), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         step(1'b0, 32'h0, 1'b1, f);

      // 5: pulse during SEND ignored, held accepted late
      step(1'b1, 32'h55667788, 1'b1, f);
      step(1'b0, 32'h0, 1'b1, f);
      step(1'b1, 32'hFFFFFFFF, 1'b0, f);
      chk("t5_pulse_rejected", 32'(f), 32'd0);
      step(1'b0, 32'h0, 1'b0, f);
      chk("t5_word_kept", 32'(out_data), 32'h66);
      chk("t5_idx_kept", 32'(out_idx), 32'd1);
      f = 1'b0;
      for (int i = 0; i < 8 && !f; i++) begin
         pidx = out_idx;
         step(1'b1, 32'hA1B2C3D4, 1'b1, f);
         chk("t5_fire_on_last", 32'(f),
             32'(pidx == 2'd3));
      end
      chk("t5_accepted", 32'(f), 32'd1);
      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h0, 1'b1, f);
      chk("t5_idle", 32'(out_valid), 32'd0);

      // 6: random handshakes, 1000 words
      words = 0;
      cyc = 0;
      nxt = $urandom;
      while (words < 1000 && cyc < 20000) begin
         step(1'($urandom_range(0, 1)), nxt,
              ($urandom_range(0, 3) != 0), f);
         if (f) begin
            words++;
            nxt = $urandom;
         end
         cyc++;
      end
      chk("t6_words", 32'(words), 32'd1000);
      for (int i = 0; i < 50 && out_valid; i++)
         step(1'b0, 32'h0, 1'b1, f);
      chk("t6_drained_valid", 32'(out_valid), 32'd0);
      chk("t6_queue_empty", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
